// File: rtl/program_loader_pkg.sv
// Shared load-FSM state encoding and frame constants for the program loader
// and the CPU top-level load-mode mux.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_WR    = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } load_state_e;

    localparam int unsigned LOAD_DEFAULT_WORDS = 8;

    // A frame must carry at least one word and no more than the RAM holds.
    function automatic logic count_valid(input logic [7:0] n, input int unsigned max_count);
        return (n != 8'd0) && (32'(n) <= max_count);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Builds a DATA_W-bit word from a low byte and a high byte and keeps the
// running XOR of every byte fed in since the last clear.
module byte_word_assembler #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              seed_i,
    input  logic              lo_i,
    input  logic              hi_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic [7:0]        xor_o
);

    logic [7:0] lo_q, lo_d;
    logic [7:0] xor_q, xor_d;

    always_comb begin
        lo_d  = lo_q;
        xor_d = xor_q;
        if (clear_i) begin
            xor_d = 8'h00;
        end else if (seed_i) begin
            xor_d = byte_i;
        end else if (lo_i) begin
            lo_d  = byte_i;
            xor_d = xor_q ^ byte_i;
        end else if (hi_i) begin
            xor_d = xor_q ^ byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q  <= 8'h00;
            xor_q <= 8'h00;
        end else begin
            lo_q  <= lo_d;
            xor_q <= xor_d;
        end
    end

    // Valid while the high byte is on byte_i; unused high-byte bits drop here.
    assign word_o = {byte_i[DATA_W-9:0], lo_q};
    assign xor_o  = xor_q;

endmodule

// File: rtl/program_loader.sv
// Streams a COUNT/words/CHK frame from a byte link into instruction RAM and
// releases the CPU only after the checksum matches.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] RAM_Write_Data,
    output logic [ADDR_W-1:0] RAM_Write_Address,
    output logic              RAM_Write_Enable,
    output logic              PC_Enable,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output load_state_e       dbg_state_o
);

    localparam int unsigned MaxCount = WORDS;

    // Handshake: a byte moves on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, and a low in_valid simply stalls.
    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        count_q, count_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

    logic              xfer;
    logic              asm_clear, asm_seed, asm_lo, asm_hi;
    logic [DATA_W-1:0] asm_word;
    logic [7:0]        asm_xor;
    logic [7:0]        addr_next8;

    byte_word_assembler #(
        .DATA_W(DATA_W)
    ) u_asm (
        .clk    (clk),
        .reset  (reset),
        .clear_i(asm_clear),
        .seed_i (asm_seed),
        .lo_i   (asm_lo),
        .hi_i   (asm_hi),
        .byte_i (in_data),
        .word_o (asm_word),
        .xor_o  (asm_xor)
    );

    assign xfer       = in_valid && in_ready;
    assign addr_next8 = 8'(addr_q) + 8'd1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        ram_data_d = ram_data_q;
        ram_addr_d = ram_addr_q;
        asm_clear  = 1'b0;
        asm_seed   = 1'b0;
        asm_lo     = 1'b0;
        asm_hi     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_COUNT;
                    addr_d    = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_COUNT: begin
                if (xfer) begin
                    if (count_valid(in_data, MaxCount)) begin
                        state_d  = ST_LO;
                        count_d  = in_data;
                        asm_seed = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LO: begin
                if (xfer) begin
                    state_d = ST_HI;
                    asm_lo  = 1'b1;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    state_d    = ST_WR;
                    asm_hi     = 1'b1;
                    ram_data_d = asm_word;
                    ram_addr_d = addr_q;
                end
            end
            ST_WR: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (addr_next8 == count_q) ? ST_CSUM : ST_LO;
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == asm_xor) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= 8'h00;
            ram_data_q <= '0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            ram_data_q <= ram_data_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign in_ready          = (state_q == ST_COUNT) || (state_q == ST_LO) ||
                               (state_q == ST_HI)    || (state_q == ST_CSUM);
    assign RAM_Write_Enable  = (state_q == ST_WR);
    assign RAM_Write_Data    = ram_data_q;
    assign RAM_Write_Address = ram_addr_q;
    assign PC_Enable         = (state_q == ST_DONE);
    assign cpu_reset         = (state_q != ST_DONE);
    assign busy              = in_ready || (state_q == ST_WR);
    assign done              = (state_q == ST_DONE);
    assign error             = (state_q == ST_ERR);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad frames, stalls, restart and reset.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int WORDS  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 11;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] RAM_Write_Data;
  logic [ADDR_W-1:0] RAM_Write_Address;
  logic RAM_Write_Enable, PC_Enable, cpu_reset, busy, done, error;
  load_state_e dbg_state;

  always #5 clk = ~clk;

  program_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .RAM_Write_Data   (RAM_Write_Data),
    .RAM_Write_Address(RAM_Write_Address),
    .RAM_Write_Enable (RAM_Write_Enable),
    .PC_Enable        (PC_Enable),
    .cpu_reset        (cpu_reset),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .dbg_state_o      (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];

  function automatic logic [15:0] wr_entry(input int a, input int d);
    return {5'(a), 11'(d)};
  endfunction

  always @(negedge clk) begin
    if (RAM_Write_Enable === 1'b1)
      act_q.push_back({5'(RAM_Write_Address), 11'(RAM_Write_Data)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all entered and left on a falling edge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_seen", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    logic [15:0] e, a;
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() > 0) a = act_q.pop_front();
      else a = 'x;
      check(tag, 32'(a), 32'(e));
    end
    check({tag, "_extra"}, act_q.size(), 0);
    act_q.delete();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},    32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_we"},       32'(RAM_Write_Enable), 0);
    check({tag, "_data"},     32'(RAM_Write_Data), 0);
    check({tag, "_addr"},     32'(RAM_Write_Address), 0);
    check({tag, "_pc_en"},    32'(PC_Enable), 0);
    check({tag, "_cpu_rst"},  32'(cpu_reset), 1);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_error"},    32'(error), 0);
  endtask

  logic [10:0] stall_words [8];
  logic [7:0]  b_lo, b_hi, chk;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(dbg_state), 32'(ST_IDLE));

    // good 2-word load
    do_start();
    check("good_busy", 32'(busy), 1);
    check("good_count_ready", 32'(in_ready), 1);
    check("good_count_state", 32'(dbg_state), 32'(ST_COUNT));
    exp_q.push_back(wr_entry(0, 11'h123));
    exp_q.push_back(wr_entry(1, 11'h7FF));
    send_byte(8'h02, 0);
    send_byte(8'h23, 0);
    send_byte(8'h01, 0);
    check("good_w0_we", 32'(RAM_Write_Enable), 1);
    check("good_w0_addr", 32'(RAM_Write_Address), 0);
    check("good_w0_data", 32'(RAM_Write_Data), 32'h123);
    check("good_w0_ready", 32'(in_ready), 0);
    send_byte(8'hFF, 0);
    check("good_w0_hold_data", 32'(RAM_Write_Data), 32'h123);
    send_byte(8'h07, 0);
    check("good_w1_we", 32'(RAM_Write_Enable), 1);
    check("good_w1_addr", 32'(RAM_Write_Address), 1);
    check("good_w1_data", 32'(RAM_Write_Data), 32'h7FF);
    send_byte(8'hD8, 0);
    check("good_done", 32'(done), 1);
    check("good_pc_en", 32'(PC_Enable), 1);
    check("good_cpu_rst", 32'(cpu_reset), 0);
    check("good_error", 32'(error), 0);
    check("good_busy_end", 32'(busy), 0);
    compare_writes("good_wr");
    check("good_done_hold", 32'(done), 1);

    // restart from DONE, then a bad checksum
    do_start();
    check("restart_pc_en", 32'(PC_Enable), 0);
    check("restart_cpu_rst", 32'(cpu_reset), 1);
    check("restart_done", 32'(done), 0);
    exp_q.push_back(wr_entry(0, 11'h123));
    exp_q.push_back(wr_entry(1, 11'h7FF));
    send_byte(8'h02, 0);
    send_byte(8'h23, 0);
    send_byte(8'h01, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h07, 0);
    send_byte(8'hD9, 0);
    check("badchk_error", 32'(error), 1);
    check("badchk_done", 32'(done), 0);
    check("badchk_pc_en", 32'(PC_Enable), 0);
    check("badchk_cpu_rst", 32'(cpu_reset), 1);
    compare_writes("badchk_wr");

    // bad counts
    do_start();
    check("cnt0_error_clr", 32'(error), 0);
    send_byte(8'h00, 0);
    check("cnt0_state", 32'(dbg_state), 32'(ST_ERR));
    check("cnt0_error", 32'(error), 1);
    compare_writes("cnt0_wr");
    do_start();
    send_byte(8'h09, 0);
    check("cnt9_state", 32'(dbg_state), 32'(ST_ERR));
    check("cnt9_busy", 32'(busy), 0);
    compare_writes("cnt9_wr");

    // full 8-word frame with random valid gaps; unused high-byte bits set
    stall_words = '{11'h001, 11'h7FF, 11'h400, 11'h555, 11'h2AA, 11'h0F0, 11'h70F, 11'h3C3};
    do_start();
    send_byte(8'h08, $urandom_range(0, 3));
    chk = 8'h08;
    for (int i = 0; i < 8; i++) begin
      b_lo = stall_words[i][7:0];
      b_hi = {5'b10101, stall_words[i][10:8]};
      chk  = chk ^ b_lo ^ b_hi;
      exp_q.push_back(wr_entry(i, stall_words[i]));
      send_byte(b_lo, $urandom_range(0, 3));
      send_byte(b_hi, $urandom_range(0, 3));
    end
    send_byte(chk, $urandom_range(0, 3));
    check("stall_done", 32'(done), 1);
    check("stall_pc_en", 32'(PC_Enable), 1);
    compare_writes("stall_wr");

    // start pulsed while in LO is ignored
    do_start();
    send_byte(8'h01, 0);
    check("bstart_in_lo", 32'(dbg_state), 32'(ST_LO));
    do_start();
    check("bstart_still_lo", 32'(dbg_state), 32'(ST_LO));
    exp_q.push_back(wr_entry(0, 11'h234));
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h27, 0);
    check("bstart_done", 32'(done), 1);
    compare_writes("bstart_wr");

    // reset after the third data byte
    do_start();
    exp_q.push_back(wr_entry(0, 11'h511));
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h05, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_hold", 32'(dbg_state), 32'(ST_IDLE));
    compare_writes("midrst_wr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image from a byte-wide host link into the CPU instruction RAM and then releases the CPU to run. Sits directly upstream of the CPU: it drives the RAM write port (`RAM_Write_Data`, `RAM_Write_Address`, `RAM_Write_Enable`), `PC_Enable`, and a CPU reset. The CPU stays halted and in reset during a load; a checksum gates release.

## Interface

One clock; reset is synchronous and active-high, on ports `clk` and `reset`.

**Parameters**
- `WORDS`, default 8: RAM depth (instruction slots).
- `ADDR_W`, default 3: RAM address width; `2**ADDR_W == WORDS`.
- `DATA_W`, default 11: instruction width; must be ≤ 16.

**Ports**
- `clk`, input, 1: system clock, shared with the CPU.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: single-cycle request to begin a load. Ignored unless state is IDLE, DONE or ERR.
- `in_data`, input, 8: host byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts the byte this cycle.
- `RAM_Write_Data`, output, DATA_W: instruction word to the CPU.
- `RAM_Write_Address`, output, ADDR_W: RAM slot.
- `RAM_Write_Enable`, output, 1: one-cycle write strobe.
- `PC_Enable`, output, 1: CPU clock gate.
- `cpu_reset`, output, 1: held-reset to the CPU.
- `busy`, output, 1: load in progress.
- `done`, output, 1: last load succeeded.
- `error`, output, 1: last load failed.

## Operation

- **Frame format:** COUNT byte N, then N words, then CHK byte.
  - Each word is sent as a low byte (bits 7:0) followed by a high byte. Bits `DATA_W-9:0` of the high byte become bits `DATA_W-1:8`; the remaining high-byte bits are ignored.
  - CHK is the XOR of COUNT and every data byte.
- **States:** IDLE → COUNT → LO → HI → WR → (LO | CSUM) → DONE, with any failure going to ERR.
- **IDLE / DONE / ERR:** on `start`, go to COUNT; clear the address counter and the running XOR.
- **COUNT:** accept one byte.
  - If N == 0 or N > WORDS: go to ERR.
  - Otherwise store N, and seed the XOR with the byte.
- **LO:** accept a byte, latch it, XOR it in; go to HI.
- **HI:** accept a byte, latch its used bits, XOR it in; go to WR.
- **WR:** pulse `RAM_Write_Enable` with the current address and the assembled word. Then:
  - Increment the address.
  - If address+1 == N, go to CSUM; else go to LO.
- **CSUM:** accept a byte. Go to DONE if it equals the running XOR, else go to ERR.
- **Handshake:** a byte transfers when `in_valid && in_ready`.
  - `in_ready` = 1 only in COUNT, LO, HI and CSUM.
  - `in_valid` low stalls the FSM indefinitely; no timeout.
- **CPU control:**
  - `cpu_reset` = 1 in every state except DONE.
  - `PC_Enable` = 1 only in DONE.
  - On a failed load, the RAM keeps the partial writes but the CPU never runs.
- **Status outputs:**
  - `busy` = 1 in COUNT, LO, HI, WR and CSUM.
  - `done` = 1 in DONE; `error` = 1 in ERR.
- **RAM outputs:** `RAM_Write_Data` and `RAM_Write_Address` are registered and hold their last value outside WR.

## Timing

- **Reset values:** state IDLE; `in_ready`=0, `RAM_Write_Enable`=0, `RAM_Write_Data`=0, `RAM_Write_Address`=0, `PC_Enable`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0.
- **Write latency:** `RAM_Write_Enable` is high the cycle after the HI byte is accepted, for exactly one cycle. The RAM captures the word on that same edge.
- **Minimum frame time:** 1 + 3N + 1 cycles after `start` is sampled (COUNT, then LO/HI/WR per word, then CSUM), assuming `in_valid` is held high.
- **Release:** `PC_Enable` rises and `cpu_reset` falls in the cycle after the CHK byte is accepted. The CPU begins at PC=0 on the next edge.
- **`start` in DONE or ERR:** `PC_Enable` drops and `cpu_reset` rises on the next cycle.
- **`start` while busy:** ignored.
- **`reset` mid-frame:** returns to IDLE next edge with the reset values above. Writes already issued are not undone, and no further write occurs.
- **Address wrap:** impossible by construction, since N ≤ WORDS.

## Structure

- **Shared package:** the state enum (IDLE, COUNT, LO, HI, WR, CSUM, DONE, ERR) and the frame constants (max count = WORDS). The CPU top-level reuses these for its load-mode mux.
- **Sub-module:** one, `byte_word_assembler`. It takes LO/HI bytes and produces a `DATA_W` word plus the running XOR, and is reused by a future data-RAM loader.

## Test plan

- **Good 2-word load:** `start`, then bytes 02, 23, 01, FF, 07, D8.
  - Expect writes 0x123@0 and 0x7FF@1, each strobe one cycle wide.
  - Then `done`=1, `PC_Enable`=1, `cpu_reset`=0.
- **Bad checksum:** same frame with CHK=D9.
  - Expect both writes to occur, then `error`=1, `PC_Enable`=0, `cpu_reset`=1.
- **Bad count:** COUNT=00, and separately COUNT=09.
  - Expect ERR immediately after the COUNT byte, with no write strobe.
- **Stalls:** full 8-word frame with `in_valid` deasserted for random gaps.
  - Expect identical writes; `in_ready` never transfers while `in_valid`=0.
- **Reset mid-frame:** assert `reset` after the 3rd data byte.
  - Expect IDLE next cycle, only one write issued, and all outputs at reset values.
- **Restart and busy-start:**
  - `start` in DONE drops `PC_Enable` next cycle.
  - `start` pulsed during LO has no effect on the frame.
